booth4_multiplier_32x32: RTL



---
 rtl/booth4_multiplier_32x32.sv | 124 ++++++++++++
 1 files changed

// File: rtl/booth4_multiplier_32x32.sv
// Iterative 32x32 radix-4 Booth multiplier, signed or unsigned, full 64-bit product.
// Digits are consumed MSB-first into a carry-save accumulator, then resolved with one add.
module booth4_multiplier_32x32 #(
  parameter int N      = 32,
  parameter int ACC_W  = 70,
  parameter int DIGITS = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand_in,
  input  logic [N-1:0]   multiplier_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product_out
);

  // Extended multiplier (N+2 bits) plus the implicit zero below bit 0.
  localparam int         BW   = N + 3;
  localparam logic [4:0] LAST = 5'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ITER, RESOLVE} state_t;

  state_t           state, state_nxt;
  logic [4:0]       cnt;
  logic [ACC_W-1:0] m_reg;
  logic [BW-1:0]    b_sr;
  logic [ACC_W-1:0] sum, carry;
  logic [ACC_W-1:0] a_ext;
  logic [BW-1:0]    b_ext;
  logic [2:0]       digit;
  logic [ACC_W-1:0] mult;
  logic             neg;
  logic [ACC_W-1:0] sum_sh, carry_sh, csa_sum, csa_carry;

  assign a_ext = {{(ACC_W-N){signed_mode & multiplicand_in[N-1]}}, multiplicand_in};
  assign b_ext = {{2{signed_mode & multiplier_in[N-1]}}, multiplier_in, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (cnt == LAST) state_nxt = RESOLVE;
      RESOLVE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The top three bits of the shift register always hold the current digit's window.
  assign digit = b_sr[BW-1 -: 3];

  always_comb begin
    mult = '0;
    neg  = 1'b0;
    case (digit)
      3'b001, 3'b010: mult = m_reg;
      3'b011:         mult = m_reg << 1;
      3'b100: begin
        mult = ~(m_reg << 1);
        neg  = 1'b1;
      end
      3'b101, 3'b110: begin
        mult = ~m_reg;
        neg  = 1'b1;
      end
      default:        mult = '0;
    endcase
  end

  // The carry vector's bit 0 is always free, so the two's-complement +1 goes there.
  always_comb begin
    sum_sh    = sum << 2;
    carry_sh  = carry << 2;
    csa_sum   = sum_sh ^ carry_sh ^ mult;
    csa_carry = (((sum_sh & carry_sh) | (sum_sh & mult) | (carry_sh & mult)) << 1)
                | ACC_W'(neg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg       <= '0;
      b_sr        <= '0;
      sum         <= '0;
      carry       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      product_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= a_ext;
            b_sr  <= b_ext;
            sum   <= '0;
            carry <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ITER: begin
          sum   <= csa_sum;
          carry <= csa_carry;
          b_sr  <= b_sr << 2;
          cnt   <= cnt + 5'd1;
        end
        RESOLVE: begin
          product_out <= (2*N)'(sum + carry);
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
